fifo_upsize_sync: RTL and testbench

Single-clock FIFO that packs narrow write beats into wide read words (RATIO:1 upsizing), with write- and read-side water levels, almost-full and almost-empty flags, and a flush that commits a partial word padded with zeros plus a per-lane keep mask. It is the parametrised successor to the fixed 32-to-256 fabric FIFO. It sits between narrow capture streams and the wide DDR/AXI write path, and is used wherever both sides share one clock.

---
 rtl/fifo_upsize_pkg.sv | 26 ++
 rtl/fifo_upsize_ram.sv | 57 +++++
 rtl/fifo_upsize_sync.sv | 143 ++++++++++++++
 tb/tb_fifo_upsize_sync.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_upsize_pkg.sv
// Shared helpers and constants for the narrow-to-wide packing FIFO.
// Widths that depend on instance parameters are derived in the modules with log2().
package fifo_upsize_pkg;

   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   localparam int DEF_WR_DATA_WIDTH  = 32;
   localparam int DEF_RATIO          = 8;
   localparam int DEF_RD_DEPTH_WIDTH = 7;
   localparam int DEF_RD_DATA_WIDTH  = DEF_WR_DATA_WIDTH * DEF_RATIO;
   localparam int DEF_RATIO_W        = log2(DEF_RATIO);
   localparam int DEF_WR_DEPTH_WIDTH = DEF_RD_DEPTH_WIDTH + DEF_RATIO_W;

   localparam logic RST_FLAG  = 1'b0;
   localparam logic RST_EMPTY = 1'b1;

endpackage

// File: rtl/fifo_upsize_ram.sv
// Simple dual-port word store (data plus keep) with registered read and an
// optional second output stage that follows the first one cycle later.
module fifo_upsize_ram #(
   parameter int DATA_W     = 264,
   parameter int ADDR_W     = 7,
   parameter int OUTPUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output holds between accepted reads, so the read register only loads on re.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q <= '0;
      end else if (re) begin
         rd_q <= mem[raddr];
      end
   end

   generate
      if (OUTPUT_REG != 0) begin : g_oreg
         logic              re_q;
         logic [DATA_W-1:0] out_q;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               re_q  <= 1'b0;
               out_q <= '0;
            end else begin
               re_q <= re;
               if (re_q) begin
                  out_q <= rd_q;
               end
            end
         end
         assign rdata = out_q;
      end else begin : g_noreg
         assign rdata = rd_q;
      end
   endgenerate

endmodule

// File: rtl/fifo_upsize_sync.sv
// Single-clock FIFO packing RATIO narrow write beats into one wide read word,
// with flush of partial words (zero padded, per-lane keep) and level flags.
module fifo_upsize_sync
   import fifo_upsize_pkg::*;
#(
   parameter int WR_DATA_WIDTH    = 32,
   parameter int RATIO            = 8,
   parameter int RD_DEPTH_WIDTH   = 7,
   parameter int OUTPUT_REG       = 0,
   parameter int ALMOST_FULL_NUM  = 1020,
   parameter int ALMOST_EMPTY_NUM = 4,
   localparam int RD_DATA_WIDTH   = WR_DATA_WIDTH * RATIO,
   localparam int RATIO_W         = log2(RATIO),
   localparam int WR_DEPTH_WIDTH  = RD_DEPTH_WIDTH + RATIO_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WR_DATA_WIDTH-1:0]  wr_data,
   input  logic                      wr_en,
   input  logic                      flush,
   output logic                      wr_full,
   output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
   output logic                      almost_full,
   input  logic                      rd_en,
   output logic [RD_DATA_WIDTH-1:0]  rd_data,
   output logic [RATIO-1:0]          rd_keep,
   output logic                      rd_empty,
   output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
   output logic                      almost_empty,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int CNT_W = (RATIO_W > 0) ? RATIO_W : 1;
   localparam int LVL_W = RD_DEPTH_WIDTH + 1;
   localparam int WLV_W = WR_DEPTH_WIDTH + 1;
   localparam int MEM_W = RD_DATA_WIDTH + RATIO;

   logic [LVL_W-1:0]          words_q, words_d;
   logic [RD_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [RD_DATA_WIDTH-1:0]  pack_q, pack_d;
   logic                      flush_pend_q, flush_pend_d;
   logic                      overflow_q, overflow_d;
   logic                      underflow_q, underflow_d;

   logic                      mem_full, mem_empty, last_lane, wr_full_c;
   logic                      wr_acc, rd_acc, commit;
   logic [CNT_W:0]            fill;
   logic [RD_DATA_WIDTH-1:0]  pack_wr;
   logic [RATIO-1:0]          commit_keep;
   logic [MEM_W-1:0]          ram_rdata;

   always_comb begin
      mem_full     = (words_q == LVL_W'(2**RD_DEPTH_WIDTH));
      mem_empty    = (words_q == '0);
      last_lane    = (cnt_q == CNT_W'(RATIO - 1));
      wr_full_c    = mem_full && (last_lane || flush_pend_q);
      wr_acc       = wr_en && !wr_full_c;
      rd_acc       = rd_en && !mem_empty;
      pack_wr      = pack_q;
      if (wr_acc) begin
         pack_wr[int'(cnt_q)*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
      end
      fill         = {1'b0, cnt_q} + {{CNT_W{1'b0}}, wr_acc};
      commit       = 1'b0;
      commit_keep  = '0;
      cnt_d        = fill[CNT_W-1:0];
      pack_d       = pack_wr;
      flush_pend_d = flush_pend_q;
      // A beat completing the word always wins over a flush of that same word.
      if (wr_acc && last_lane) begin
         commit      = 1'b1;
         commit_keep = '1;
         cnt_d       = '0;
         pack_d      = '0;
      end else if ((flush || flush_pend_q) && (fill != '0)) begin
         if (!mem_full) begin
            commit       = 1'b1;
            commit_keep  = RATIO'(({{RATIO{1'b0}}, 1'b1} << fill) - 1'b1);
            cnt_d        = '0;
            pack_d       = '0;
            flush_pend_d = 1'b0;
         end else begin
            flush_pend_d = 1'b1;
         end
      end
      words_d     = words_q + LVL_W'(commit) - LVL_W'(rd_acc);
      wr_ptr_d    = wr_ptr_q + RD_DEPTH_WIDTH'(commit);
      rd_ptr_d    = rd_ptr_q + RD_DEPTH_WIDTH'(rd_acc);
      overflow_d  = overflow_q | (wr_en & wr_full_c);
      underflow_d = underflow_q | (rd_en & mem_empty);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         words_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         pack_q       <= '0;
         flush_pend_q <= RST_FLAG;
         overflow_q   <= RST_FLAG;
         underflow_q  <= RST_FLAG;
      end else begin
         words_q      <= words_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         pack_q       <= pack_d;
         flush_pend_q <= flush_pend_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   fifo_upsize_ram #(
      .DATA_W     (MEM_W),
      .ADDR_W     (RD_DEPTH_WIDTH),
      .OUTPUT_REG (OUTPUT_REG)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (commit),
      .waddr (wr_ptr_q),
      .wdata ({commit_keep, pack_wr}),
      .re    (rd_acc),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign rd_data        = ram_rdata[RD_DATA_WIDTH-1:0];
   assign rd_keep        = ram_rdata[MEM_W-1 -: RATIO];
   assign wr_full        = wr_full_c;
   assign rd_empty       = mem_empty;
   assign rd_water_level = words_q;
   assign wr_water_level = (WLV_W'(words_q) << RATIO_W) + WLV_W'(cnt_q);
   assign almost_full    = (wr_water_level >= WLV_W'(ALMOST_FULL_NUM));
   assign almost_empty   = (words_q <= LVL_W'(ALMOST_EMPTY_NUM));
   assign overflow       = overflow_q;
   assign underflow      = underflow_q;

endmodule

// File: tb/tb_fifo_upsize_sync.sv
// Directed bench for fifo_upsize_sync: default instance plus an OUTPUT_REG=1
// instance driven by the same stimulus for the read-latency comparison.
module tb_fifo_upsize_sync;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wr_en = 1'b0;
   logic         flush = 1'b0;
   logic         rd_en = 1'b0;
   logic [31:0]  wr_data = '0;

   logic         wr_full_0, almost_full_0, rd_empty_0, almost_empty_0, overflow_0, underflow_0;
   logic [10:0]  wr_lvl_0;
   logic [7:0]   rd_lvl_0;
   logic [255:0] rd_data_0;
   logic [7:0]   rd_keep_0;

   logic         wr_full_1, almost_full_1, rd_empty_1, almost_empty_1, overflow_1, underflow_1;
   logic [10:0]  wr_lvl_1;
   logic [7:0]   rd_lvl_1;
   logic [255:0] rd_data_1;
   logic [7:0]   rd_keep_1;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [255:0] exp_w;
   logic [255:0] part_w;
   logic [255:0] abc_w;

   always #5 clk = ~clk;

   fifo_upsize_sync u_dut0 (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
      .wr_full(wr_full_0), .wr_water_level(wr_lvl_0), .almost_full(almost_full_0),
      .rd_en(rd_en), .rd_data(rd_data_0), .rd_keep(rd_keep_0), .rd_empty(rd_empty_0),
      .rd_water_level(rd_lvl_0), .almost_empty(almost_empty_0),
      .overflow(overflow_0), .underflow(underflow_0)
   );

   fifo_upsize_sync #(.OUTPUT_REG(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
      .wr_full(wr_full_1), .wr_water_level(wr_lvl_1), .almost_full(almost_full_1),
      .rd_en(rd_en), .rd_data(rd_data_1), .rd_keep(rd_keep_1), .rd_empty(rd_empty_1),
      .rd_water_level(rd_lvl_1), .almost_empty(almost_empty_1),
      .overflow(overflow_1), .underflow(underflow_1)
   );

   task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [255:0] down_word(input int k);
      logic [255:0] w;
      for (int j = 0; j < 8; j++) begin
         w[j*32 +: 32] = 32'hFFFF_FFFF - 32'(8*k + j);
      end
      return w;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_rd_data"}, rd_data_0, 0);
      check({tag, "_rd_keep"}, rd_keep_0, 0);
      check({tag, "_wr_full"}, wr_full_0, 0);
      check({tag, "_rd_empty"}, rd_empty_0, 1);
      check({tag, "_almost_empty"}, almost_empty_0, 1);
      check({tag, "_almost_full"}, almost_full_0, 0);
      check({tag, "_wr_level"}, wr_lvl_0, 0);
      check({tag, "_rd_level"}, rd_lvl_0, 0);
      check({tag, "_overflow"}, overflow_0, 0);
      check({tag, "_underflow"}, underflow_0, 0);
      check({tag, "_rd_data_oreg"}, rd_data_1, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      step();
      step();
      check_reset_state("reset");
      rst_n = 1'b1;

      // fill: 1024 beats counting down from 0xFFFFFFFF
      for (int i = 0; i < 1024; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'hFFFF_FFFF - 32'(i);
         step();
         if (i == 1018) check("af_at_1019", almost_full_0, 0);
         if (i == 1019) check("af_at_1020", almost_full_0, 1);
         if (i == 1022) check("full_at_1023", wr_full_0, 0);
      end
      wr_en = 1'b0;
      check("fill_rd_level", rd_lvl_0, 128);
      check("fill_wr_level", wr_lvl_0, 1024);
      check("fill_wr_full_pack_empty", wr_full_0, 0);
      check("fill_almost_full", almost_full_0, 1);
      check("fill_almost_empty", almost_empty_0, 0);

      // memory full, three beats into the pack register, then flush
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'h100 + 32'(i);
         step();
      end
      wr_en = 1'b0;
      check("pack3_wr_level", wr_lvl_0, 1027);
      check("pack3_wr_full", wr_full_0, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_pend_wr_full", wr_full_0, 1);
      check("flush_pend_rd_level", rd_lvl_0, 128);

      wr_en   = 1'b1;
      wr_data = 32'hDEAD_BEEF;
      step();
      wr_en = 1'b0;
      check("ovf_flag", overflow_0, 1);
      check("ovf_wr_level", wr_lvl_0, 1027);

      // one read frees space; the pending partial commits on the next edge
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      exp_w = down_word(0);
      check("rd0_data", rd_data_0, exp_w);
      check("rd0_keep", rd_keep_0, 8'hFF);
      check("rd0_level", rd_lvl_0, 127);
      check("rd0_oreg_not_yet", rd_data_1, 0);
      step();
      check("rd0_oreg_data", rd_data_1, exp_w);
      check("rd0_oreg_keep", rd_keep_1, 8'hFF);
      check("pend_commit_level", rd_lvl_0, 128);
      check("pend_commit_wr_level", wr_lvl_0, 1024);
      check("pend_commit_wr_full", wr_full_0, 0);

      // drain: words 1..127 then the flushed partial word
      for (int k = 1; k < 128; k++) begin
         rd_en = 1'b1;
         step();
         exp_w = down_word(k);
         check($sformatf("drain%0d_data", k), rd_data_0, exp_w);
         check($sformatf("drain%0d_keep", k), rd_keep_0, 8'hFF);
         check($sformatf("drain%0d_level", k), rd_lvl_0, 128 - k);
         check($sformatf("drain%0d_aempty", k), almost_empty_0, (128 - k) <= 4);
      end
      step();
      part_w = {160'h0, 32'h102, 32'h101, 32'h100};
      check("partial_data", rd_data_0, part_w);
      check("partial_keep", rd_keep_0, 8'h07);
      check("partial_empty", rd_empty_0, 1);

      // read while empty
      step();
      rd_en = 1'b0;
      check("unf_flag", underflow_0, 1);
      check("unf_data_held", rd_data_0, part_w);
      check("unf_keep_held", rd_keep_0, 8'h07);
      check("unf_oreg_data", rd_data_1, part_w);

      // A, B, C then flush
      wr_en = 1'b1;
      wr_data = 32'hA;
      step();
      wr_data = 32'hB;
      step();
      wr_data = 32'hC;
      step();
      wr_en = 1'b0;
      check("abc_wr_level", wr_lvl_0, 3);
      check("abc_rd_level", rd_lvl_0, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("abc_flush_rd_level", rd_lvl_0, 1);
      check("abc_flush_wr_level", wr_lvl_0, 8);
      check("abc_flush_empty", rd_empty_0, 0);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      abc_w = {160'h0, 32'hC, 32'hB, 32'hA};
      check("abc_data", rd_data_0, abc_w);
      check("abc_keep", rd_keep_0, 8'h07);
      check("abc_oreg_lag", rd_data_1, part_w);
      step();
      check("abc_oreg_data", rd_data_1, abc_w);
      check("abc_oreg_keep", rd_keep_1, 8'h07);

      // write and flush in the same cycle, then a flush with nothing packed
      wr_en   = 1'b1;
      wr_data = 32'hD;
      flush   = 1'b1;
      step();
      wr_en = 1'b0;
      check("wrflush_rd_level", rd_lvl_0, 1);
      check("wrflush_wr_level", wr_lvl_0, 8);
      step();
      flush = 1'b0;
      check("noop_flush_level", rd_lvl_0, 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      exp_w = {224'h0, 32'hD};
      check("wrflush_data", rd_data_0, exp_w);
      check("wrflush_keep", rd_keep_0, 8'h01);

      // steady state at 64 words: one read lands on each commit edge
      for (int n = 0; n < 512; n++) begin
         wr_en   = 1'b1;
         wr_data = 32'h1000 + 32'(n);
         step();
      end
      wr_en = 1'b0;
      check("steady_start_level", rd_lvl_0, 64);
      for (int p = 0; p < 8; p++) begin
         for (int j = 0; j < 8; j++) begin
            wr_en   = 1'b1;
            wr_data = 32'h2000 + 32'(p*8 + j);
            rd_en   = (j == 7);
            step();
            check($sformatf("steady_p%0d_j%0d_level", p, j), rd_lvl_0, 64);
         end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      for (int j = 0; j < 8; j++) begin
         exp_w[j*32 +: 32] = 32'h1000 + 32'(56 + j);
      end
      check("steady_last_data", rd_data_0, exp_w);

      // reset in the middle of a partial word
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'h3000 + 32'(i);
         step();
      end
      wr_en = 1'b0;
      rst_n = 1'b0;
      step();
      check_reset_state("midreset");
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'h4000 + 32'(i);
         step();
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      for (int j = 0; j < 8; j++) begin
         exp_w[j*32 +: 32] = 32'h4000 + 32'(j);
      end
      check("post_reset_data", rd_data_0, exp_w);
      check("post_reset_keep", rd_keep_0, 8'hFF);
      check("post_reset_empty", rd_empty_0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
